code_lock_ctrl: RTL and testbench

- Parametrised combination-lock controller for the board push-buttons.
- Synchronises and debounces NUM_SW switch inputs and turns each release into a one-cycle digit event.
- Matches the digit events against a CODE_LEN-digit code parameter and drives unlock/lockout indicators.
- Adds what earlier lock logic lacked: debounce, entry timeout, failed-attempt counter with timed lockout, and progress/status outputs.

---
 rtl/code_lock_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl
// Combination-lock controller for the board push-buttons. Each switch channel
// is synchronised, debounced, and its release turns into a one-cycle digit
// event. Digit events are matched against the CODE parameter. The block also
// provides an idle timeout during entry, a failed-attempt counter and a timed
// lockout.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   sw         in   raw switch levels (1 = pressed), asynchronous to clk
//   sw_led     out  registered copy of the debounced switch levels
//   unlocked   out  high while the lock is open
//   locked_out out  high during the lockout period
//   progress   out  number of correct digits entered so far
//   fail_cnt   out  wrong digits since the last success or lockout
module code_lock_ctrl #(
    parameter int NUM_SW          = 4,
    parameter int CODE_LEN        = 5,
    parameter int IDX_W           = 2,
    parameter logic [CODE_LEN*IDX_W-1:0] CODE = 10'b11_10_01_00_00,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int TIMEOUT_CYCLES  = 60000000,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 120000000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SW-1:0]                 sw,
    output logic [NUM_SW-1:0]                 sw_led,
    output logic                              unlocked,
    output logic                              locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]     progress,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt
);

    localparam int PROG_W = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES  > 2) ? $clog2(TIMEOUT_CYCLES)  : 1;
    localparam int LO_W   = (LOCKOUT_CYCLES  > 2) ? $clog2(LOCKOUT_CYCLES)  : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LO_W-1:0]   LO_LAST   = LO_W'(LOCKOUT_CYCLES - 1);
    localparam logic [PROG_W-1:0] IDX_LAST  = PROG_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);

    typedef enum logic [1:0] {
        S_ENTRY    = 2'd0,
        S_UNLOCKED = 2'd1,
        S_LOCKOUT  = 2'd2
    } state_t;

    // Code digit k of the packed CODE parameter (digit 0 entered first).
    function automatic logic [IDX_W-1:0] code_digit(input logic [PROG_W-1:0] k);
        code_digit = '0;
        for (int j = 0; j < CODE_LEN; j++) begin
            if (k == PROG_W'(j)) begin
                code_digit = CODE[j*IDX_W +: IDX_W];
            end
        end
    endfunction

    // Index of the set bit of a single-hot event vector.
    function automatic logic [IDX_W-1:0] ev_digit(input logic [NUM_SW-1:0] ev);
        ev_digit = '0;
        for (int j = 0; j < NUM_SW; j++) begin
            if (ev[j]) begin
                ev_digit = IDX_W'(j);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser, debounce and release detection
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_db;
    logic [NUM_SW-1:0] r_db_d;
    logic [NUM_SW-1:0] r_sw_led;
    logic [DB_W-1:0]   r_db_cnt [NUM_SW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_db_d   <= '0;
            r_sw_led <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1  <= sw;
            r_sync2  <= r_sync1;
            r_db_d   <= r_db;
            r_sw_led <= r_db;
            for (int i = 0; i < NUM_SW; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic [NUM_SW-1:0] w_ev;
    logic              w_any_ev;
    logic              w_multi;
    logic [IDX_W-1:0]  w_digit;

    assign w_ev     = r_db_d & ~r_db;
    assign w_any_ev = |w_ev;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi  = |(w_ev & (w_ev - NUM_SW'(1)));
    assign w_digit  = ev_digit(w_ev);

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic [PROG_W-1:0] r_idx, w_idx_nxt;
    logic [FAIL_W-1:0] r_fails, w_fails_nxt;
    logic [TO_W-1:0]   r_to_cnt, w_to_nxt;
    logic [LO_W-1:0]   r_lo_cnt, w_lo_nxt;
    logic              r_unlocked;
    logic              r_locked_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_ENTRY;
            r_idx        <= '0;
            r_fails      <= '0;
            r_to_cnt     <= '0;
            r_lo_cnt     <= '0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_fails      <= w_fails_nxt;
            r_to_cnt     <= w_to_nxt;
            r_lo_cnt     <= w_lo_nxt;
            r_unlocked   <= (w_state_nxt == S_UNLOCKED);
            r_locked_out <= (w_state_nxt == S_LOCKOUT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_fails_nxt = r_fails;
        // Idle and lockout counters only run in their own situations and
        // otherwise sit at zero, so they start clean on every entry.
        w_to_nxt    = '0;
        w_lo_nxt    = '0;

        unique case (r_state)
            S_ENTRY: begin
                if (w_any_ev) begin
                    if (!w_multi && (w_digit == code_digit(r_idx))) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = S_UNLOCKED;
                            w_idx_nxt   = '0;
                            w_fails_nxt = '0;
                        end else begin
                            w_idx_nxt = r_idx + PROG_W'(1);
                        end
                    end else begin
                        // A wrong digit restarts entry; it is not retried as digit 0.
                        w_idx_nxt = '0;
                        if (r_fails == FAIL_LAST) begin
                            w_state_nxt = S_LOCKOUT;
                            w_fails_nxt = '0;
                        end else begin
                            w_fails_nxt = r_fails + FAIL_W'(1);
                        end
                    end
                end else if (r_idx != '0) begin
                    if (r_to_cnt == TO_LAST) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_to_nxt = r_to_cnt + TO_W'(1);
                    end
                end
            end

            S_UNLOCKED: begin
                if (w_any_ev) begin
                    if (!w_multi && (w_digit == code_digit('0))) begin
                        if (CODE_LEN == 1) begin
                            w_state_nxt = S_UNLOCKED;
                            w_idx_nxt   = '0;
                        end else begin
                            w_state_nxt = S_ENTRY;
                            w_idx_nxt   = PROG_W'(1);
                        end
                    end else begin
                        w_state_nxt = S_ENTRY;
                        w_idx_nxt   = '0;
                    end
                end
            end

            S_LOCKOUT: begin
                if (r_lo_cnt == LO_LAST) begin
                    w_state_nxt = S_ENTRY;
                    w_idx_nxt   = '0;
                    w_fails_nxt = '0;
                end else begin
                    w_lo_nxt = r_lo_cnt + LO_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_ENTRY;
                w_idx_nxt   = '0;
                w_fails_nxt = '0;
            end
        endcase
    end

    assign sw_led     = r_sw_led;
    assign unlocked   = r_unlocked;
    assign locked_out = r_locked_out;
    assign progress   = r_idx;
    assign fail_cnt   = r_fails;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed testbench for code_lock_ctrl with short debounce, timeout and
// lockout periods. Inputs change on the falling clock edge; outputs are
// sampled on the falling edge.
module tb_code_lock_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] sw_led;
    logic       unlocked;
    logic       locked_out;
    logic [2:0] progress;
    logic [1:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    code_lock_ctrl #(
        .NUM_SW          (4),
        .CODE_LEN        (5),
        .IDX_W           (2),
        .CODE            (10'b11_10_01_00_00),
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64),
        .MAX_FAILS       (3),
        .LOCKOUT_CYCLES  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .sw_led     (sw_led),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .progress   (progress),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a switch pattern 10 cycles, release, then leave a 10-cycle gap.
    // The release event is consumed 7 edges after the release.
    task automatic press(input logic [3:0] m);
        sw = m;
        repeat (10) @(negedge clk);
        sw = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        sw  = 4'b0000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_unlocked", 32'(unlocked), 32'd0);
        chk("rst_locked", 32'(locked_out), 32'd0);
        chk("rst_progress", 32'(progress), 32'd0);
        chk("rst_fail", 32'(fail_cnt), 32'd0);
        chk("rst_swled", 32'(sw_led), 32'd0);
        rst = 1'b0;

        // Mid-stream asynchronous reset
        press(4'b0001);
        chk("pre_rst_progress", 32'(progress), 32'd1);
        sw = 4'b0010;
        repeat (8) @(negedge clk);
        chk("held_swled", 32'(sw_led), 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_progress", 32'(progress), 32'd0);
        chk("async_rst_swled", 32'(sw_led), 32'd0);
        chk("async_rst_unlocked", 32'(unlocked), 32'd0);
        chk("async_rst_fail", 32'(fail_cnt), 32'd0);
        sw = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Short glitch must be filtered
        sw = 4'b0001;
        repeat (2) @(negedge clk);
        sw = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("glitch_swled", 32'(sw_led), 32'd0);
        end
        chk("glitch_progress", 32'(progress), 32'd0);

        // Correct code 0,0,1,2,3
        press(4'b0001);
        chk("code_p1", 32'(progress), 32'd1);
        press(4'b0001);
        chk("code_p2", 32'(progress), 32'd2);
        press(4'b0010);
        chk("code_p3", 32'(progress), 32'd3);
        press(4'b0100);
        chk("code_p4", 32'(progress), 32'd4);
        sw = 4'b1000;
        repeat (10) @(negedge clk);
        sw = 4'b0000;
        repeat (6) @(negedge clk);
        chk("unlock_before", 32'(unlocked), 32'd0);
        @(negedge clk);
        chk("unlock_edge", 32'(unlocked), 32'd1);
        chk("unlock_progress", 32'(progress), 32'd0);
        chk("unlock_fail", 32'(fail_cnt), 32'd0);
        repeat (3) @(negedge clk);

        // Release of code digit 0 while unlocked starts a new entry
        press(4'b0001);
        chk("relock_unlocked", 32'(unlocked), 32'd0);
        chk("relock_progress", 32'(progress), 32'd1);

        // Let that entry time out before the wrong-digit test
        repeat (70) @(negedge clk);
        chk("idle_progress", 32'(progress), 32'd0);
        chk("idle_fail", 32'(fail_cnt), 32'd0);

        // Wrong digit after two correct ones
        press(4'b0001);
        press(4'b0001);
        chk("wrong_pre", 32'(progress), 32'd2);
        press(4'b1000);
        chk("wrong_progress", 32'(progress), 32'd0);
        chk("wrong_fail", 32'(fail_cnt), 32'd1);
        press(4'b0001);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        chk("recover_unlocked", 32'(unlocked), 32'd1);
        chk("recover_fail", 32'(fail_cnt), 32'd0);

        // Wrong digit while unlocked: back to entry, no failure
        press(4'b1000);
        chk("unl_wrong_unlocked", 32'(unlocked), 32'd0);
        chk("unl_wrong_progress", 32'(progress), 32'd0);
        chk("unl_wrong_fail", 32'(fail_cnt), 32'd0);

        // Three wrong digits -> lockout
        press(4'b1000);
        chk("lo_fail1", 32'(fail_cnt), 32'd1);
        press(4'b1000);
        chk("lo_fail2", 32'(fail_cnt), 32'd2);
        sw = 4'b1000;
        repeat (10) @(negedge clk);
        sw = 4'b0000;
        repeat (6) @(negedge clk);
        chk("lo_before", 32'(locked_out), 32'd0);
        @(negedge clk);
        chk("lo_enter", 32'(locked_out), 32'd1);
        chk("lo_fail_clr", 32'(fail_cnt), 32'd0);
        // Digit during lockout is ignored
        sw = 4'b0001;
        repeat (10) @(negedge clk);
        sw = 4'b0000;
        repeat (10) @(negedge clk);
        chk("lo_ignore_progress", 32'(progress), 32'd0);
        chk("lo_ignore_locked", 32'(locked_out), 32'd1);
        repeat (11) @(negedge clk);
        chk("lo_last_cycle", 32'(locked_out), 32'd1);
        @(negedge clk);
        chk("lo_exit", 32'(locked_out), 32'd0);
        chk("lo_exit_progress", 32'(progress), 32'd0);
        chk("lo_exit_fail", 32'(fail_cnt), 32'd0);
        press(4'b0001);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        press(4'b1000);
        chk("post_lo_unlocked", 32'(unlocked), 32'd1);

        // Timeout mid-entry
        press(4'b1000);
        press(4'b0001);
        sw = 4'b0001;
        repeat (10) @(negedge clk);
        sw = 4'b0000;
        repeat (7) @(negedge clk);
        chk("to_start", 32'(progress), 32'd2);
        repeat (63) @(negedge clk);
        chk("to_63", 32'(progress), 32'd2);
        @(negedge clk);
        chk("to_64", 32'(progress), 32'd0);
        chk("to_fail", 32'(fail_cnt), 32'd0);
        repeat (6) @(negedge clk);
        chk("to_70", 32'(progress), 32'd0);

        // Simultaneous release of sw[0] and sw[1] is a wrong digit
        press(4'b0011);
        chk("multi_fail", 32'(fail_cnt), 32'd1);
        chk("multi_progress", 32'(progress), 32'd0);
        chk("multi_unlocked", 32'(unlocked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
